// File: rtl/vixen_pkg.sv
// Shared definitions for the vixen video subsystem: bus width defaults and
// the VRAM arbiter state encoding.
package vixen_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;
    localparam int STALL_W    = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_WAIT = 2'd1,
        CPU_ACK  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video fetches win every cycle, the CPU is served in the gaps.
// Optional feature: define VRAM_ARB_STALL_COUNT_EN to add the 16-bit stall_count output.
module vram_arbiter
    import vixen_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
`ifdef VRAM_ARB_STALL_COUNT_EN
    output logic [STALL_W-1:0] stall_count,
`endif
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_en,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    arb_state_t        state_reg, state_next;
    logic              cpu_grant;
    logic              vid_grant_d_reg;
    logic [DATA_W-1:0] vid_hold_reg;
    logic [ADDR_W-1:0] addr_hold_reg;

    always_comb begin
        state_next = state_reg;
        cpu_grant  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cpu_req) begin
                    if (vid_en) begin
                        state_next = CPU_WAIT;
                    end else begin
                        cpu_grant  = 1'b1;
                        state_next = CPU_ACK;
                    end
                end
            end
            CPU_WAIT: begin
                // A request withdrawn while waiting is dropped without touching the RAM.
                if (!cpu_req) begin
                    state_next = IDLE;
                end else if (!vid_en) begin
                    cpu_grant  = 1'b1;
                    state_next = CPU_ACK;
                end
            end
            CPU_ACK: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ram_addr  = addr_hold_reg;
        ram_we    = 1'b0;
        ram_wdata = cpu_wdata;
        if (vid_en) begin
            ram_addr = vid_addr;
        end else if (cpu_grant) begin
            ram_addr = cpu_addr;
            ram_we   = cpu_we;
        end
    end

    assign cpu_ready = (state_reg == CPU_ACK);
    assign cpu_rdata = ram_rdata;

    // Fresh fetch data is bypassed straight through; the register keeps it afterwards.
    assign vid_data = vid_grant_d_reg ? ram_rdata : vid_hold_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            vid_grant_d_reg <= 1'b0;
            vid_hold_reg    <= '0;
            addr_hold_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            vid_grant_d_reg <= vid_en;
            addr_hold_reg   <= ram_addr;
            if (vid_grant_d_reg) begin
                vid_hold_reg <= ram_rdata;
            end
        end
    end

`ifdef VRAM_ARB_STALL_COUNT_EN
    logic [STALL_W-1:0] stall_cnt_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_reg <= '0;
        end else if (state_reg == CPU_WAIT && stall_cnt_reg != {STALL_W{1'b1}}) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    assign stall_count = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: external synchronous RAM, a cycle-level reference
// model of the grant rules, and directed scenarios with literal expectations.
module tb_vram_arbiter;

    localparam int AW = 16;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          vid_en = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic [DW-1:0] vid_data;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ready;
    logic [DW-1:0] cpu_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;
`ifdef VRAM_ARB_STALL_COUNT_EN
    logic [15:0]   stall_count;
`endif

    // Preload port shared by the RAM and the model so both start identical.
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    int pass_cnt = 0;
    int total_cnt = 0;
    int we_count = 0;
    int ready_count = 0;

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
`ifdef VRAM_ARB_STALL_COUNT_EN
        .stall_count(stall_count),
`endif
        .clk(clk),
        .reset(reset),
        .vid_en(vid_en),
        .vid_addr(vid_addr),
        .vid_data(vid_data),
        .cpu_req(cpu_req),
        .cpu_we(cpu_we),
        .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready),
        .cpu_rdata(cpu_rdata),
        .ram_addr(ram_addr),
        .ram_we(ram_we),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram_mem [0:65535];

    always @(posedge clk) begin
        if (pl_en) begin
            ram_mem[pl_addr] <= pl_data;
        end else if (ram_we) begin
            ram_mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= ram_mem[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the CPU may take the RAM whenever it requests, video is
    // absent, and it was not granted in the previous cycle (that cycle is its ack).
    logic [DW-1:0] model_mem [0:65535];
    logic          m_ack = 1'b0;
    logic          m_in_wait = 1'b0;
    logic [AW-1:0] m_last_addr = '0;
    logic [DW-1:0] m_vid_exp = '0;
    logic [DW-1:0] m_rd_exp = '0;
    logic          m_rd_valid = 1'b0;
    logic [15:0]   m_stall = '0;
    logic          m_g;
    logic [AW-1:0] m_ea;

    always @(negedge clk) begin
        if (pl_en) model_mem[pl_addr] = pl_data;
        if (ram_we) we_count++;
        if (cpu_ready) ready_count++;
        if (reset) begin
            check("rst_ram_we", ram_we, 1'b0);
            check("rst_cpu_ready", cpu_ready, 1'b0);
            check("rst_vid_data", vid_data, 8'h00);
            m_ack       = 1'b0;
            m_in_wait   = 1'b0;
            m_last_addr = '0;
            m_vid_exp   = '0;
            m_rd_valid  = 1'b0;
            m_stall     = '0;
        end else begin
            m_g  = cpu_req && !vid_en && !m_ack;
            m_ea = vid_en ? vid_addr : (m_g ? cpu_addr : m_last_addr);
            check("m_ram_addr", ram_addr, m_ea);
            check("m_ram_we", ram_we, m_g && cpu_we);
            if (m_g && cpu_we) check("m_ram_wdata", ram_wdata, cpu_wdata);
            check("m_cpu_ready", cpu_ready, m_ack);
            if (m_ack && m_rd_valid) check("m_cpu_rdata", cpu_rdata, m_rd_exp);
            check("m_vid_data", vid_data, m_vid_exp);
`ifdef VRAM_ARB_STALL_COUNT_EN
            check("m_stall_count", stall_count, m_stall);
`endif
            if (m_in_wait && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
            m_in_wait = cpu_req && vid_en && !m_ack;
            if (vid_en) m_vid_exp = model_mem[vid_addr];
            if (m_g) begin
                m_rd_valid = !cpu_we;
                m_rd_exp   = model_mem[cpu_addr];
                if (cpu_we) model_mem[cpu_addr] = cpu_wdata;
            end
            m_last_addr = m_ea;
            m_ack       = m_g;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    // Holds one CPU request until cpu_ready, with video strobes taken from vpat.
    task automatic cpu_op(input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input logic [7:0] vpat);
        logic done;
        done = 1'b0;
        for (int c = 0; c < 16 && !done; c++) begin
            step();
            cpu_req   = 1'b1;
            cpu_we    = we;
            cpu_addr  = addr;
            cpu_wdata = data;
            vid_en    = vpat[c % 8];
            vid_addr  = 16'hF600 + 16'(c);
            sample();
            if (cpu_ready) done = 1'b1;
        end
        check("cpu_op_done", done, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, expected finish before t=100000");
        $fatal(1, "timeout");
    end

    initial begin
        int we0;
        int rdy0;

        // Reset with RAM preload: 0xF600 = 0x41, rest of the window cleared.
        for (int a = 0; a < 16; a++) begin
            step();
            pl_en   = 1'b1;
            pl_addr = 16'hF600 + 16'(a);
            pl_data = (a == 0) ? 8'h41 : 8'h00;
        end
        step();
        pl_en = 1'b0;
        sample();
        check("reset_cpu_ready", cpu_ready, 1'b0);
        check("reset_ram_we", ram_we, 1'b0);
        check("reset_vid_data", vid_data, 8'h00);
        step();
        reset = 1'b0;
        sample();

        // CPU read with video idle.
        step();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hF600;
        sample();
        check("r30_grant_addr", ram_addr, 16'hF600);
        check("r30_grant_we", ram_we, 1'b0);
        check("r30_not_ready", cpu_ready, 1'b0);
        step();
        sample();
        check("r30_ready", cpu_ready, 1'b1);
        check("r30_rdata", cpu_rdata, 8'h41);
        step();
        cpu_req = 1'b0;
        sample();
        check("r30_ready_one_cycle", cpu_ready, 1'b0);

        // CPU write colliding with a video fetch.
        we0 = we_count;
        step();
        vid_en = 1'b1; vid_addr = 16'hF600;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hF601; cpu_wdata = 8'h5A;
        sample();
        check("r31_vid_addr", ram_addr, 16'hF600);
        check("r31_vid_we", ram_we, 1'b0);
        step();
        vid_en = 1'b0;
        sample();
        check("r31_cpu_addr", ram_addr, 16'hF601);
        check("r31_cpu_we", ram_we, 1'b1);
        check("r31_cpu_wdata", ram_wdata, 8'h5A);
        check("r31_vid_bypass", vid_data, 8'h41);
        step();
        sample();
        check("r31_ready", cpu_ready, 1'b1);
        check("r31_ack_we", ram_we, 1'b0);
        step();
        cpu_req = 1'b0; cpu_we = 1'b0;
        sample();
        step();
        sample();
        check("r31_we_once", we_count - we0, 1);
        check("r31_mem", ram_mem[16'hF601], 8'h5A);

        // Mixed traffic, back-to-back: fill 0xF600..0xF607 with 0..7, then read back.
        for (int i = 0; i < 8; i++) begin
            cpu_op(1'b1, 16'hF600 + 16'(i), 8'(i), 8'b0100_1011 >> (i % 3));
        end
        cpu_op(1'b0, 16'hF602, 8'h00, 8'b0000_0111);
        cpu_op(1'b0, 16'hF605, 8'h00, 8'b0101_0101);
        cpu_op(1'b0, 16'hF607, 8'h00, 8'b0000_0000);
        step();
        cpu_req = 1'b0; cpu_we = 1'b0; vid_en = 1'b0;
        sample();
        check("mix_mem5", ram_mem[16'hF605], 8'h05);

        // Video strobe every 8 cycles; each result held for 8 cycles.
        for (int i = 0; i < 8; i++) begin
            step();
            vid_en = 1'b1; vid_addr = 16'hF600 + 16'(i);
            sample();
            if (i > 0) check("r32_hold8", vid_data, i - 1);
            for (int k = 1; k < 8; k++) begin
                step();
                vid_en = 1'b0;
                sample();
                check("r32_vid", vid_data, i);
            end
        end
        step();
        sample();
        check("r32_last_hold", vid_data, 8'h07);

        // Reset pulse clears the stall counter before the wait scenario.
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;

        // CPU read held while video occupies the RAM for 3 cycles.
        step();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hF603;
        vid_en = 1'b1; vid_addr = 16'hF607;
        sample();
        check("r33_c0_ready", cpu_ready, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            step();
            vid_en = (k < 3);
            sample();
            check("r33_wait_ready", cpu_ready, 1'b0);
            check("r33_wait_we", ram_we, 1'b0);
        end
        check("r33_grant_addr", ram_addr, 16'hF603);
        step();
        sample();
        check("r33_ready", cpu_ready, 1'b1);
        check("r33_rdata", cpu_rdata, 8'h03);
`ifdef VRAM_ARB_STALL_COUNT_EN
        check("r33_stall_count", stall_count, 16'd3);
`endif
        step();
        cpu_req = 1'b0; vid_en = 1'b0;
        sample();

        // Reset while a write waits behind video.
        we0  = we_count;
        rdy0 = ready_count;
        step();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hF605; cpu_wdata = 8'hAA;
        vid_en = 1'b1; vid_addr = 16'hF600;
        sample();
        step();
        sample();
        step();
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; vid_en = 1'b0;
        sample();
        step();
        sample();
        step();
        reset = 1'b0;
        sample();
        for (int k = 0; k < 3; k++) begin
            step();
            sample();
        end
        check("r34_no_we", we_count - we0, 0);
        check("r34_no_ready", ready_count - rdy0, 0);
        check("r34_mem_kept", ram_mem[16'hF605], 8'h05);
        step();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hF605;
        sample();
        check("r34_idle_grant", ram_addr, 16'hF605);
        step();
        sample();
        check("r34_ready", cpu_ready, 1'b1);
        check("r34_rdata", cpu_rdata, 8'h05);
        step();
        cpu_req = 1'b0;
        sample();
        step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
